regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised successor to the team's 8 x 16-bit RISC register file: a RAM_DEPTH x DATA_WIDTH register file with two combinational read ports, one synchronous write port, write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard for in-flight writes. After reset, a clear state machine zeroes one register per cycle and then asserts `ready`. The block sits between decode (reads, reservations) and writeback (writes) in the pipelined core.

## Interface
- DATA_WIDTH, 16, register width in bits
- ADDRESS_WIDTH, 3, register address width
- RAM_DEPTH, 1 << ADDRESS_WIDTH, number of registers
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, is never busy
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- read_addr1, read_addr2  input  ADDRESS_WIDTH  read port addresses
- read_data1, read_data2  output  DATA_WIDTH  read port data (combinational)
- busy1, busy2  output  1  scoreboard bit for read_addr1 / read_addr2
- write_addr  input  ADDRESS_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- write_en  input  1  write strobe; also clears the busy bit of write_addr
- reserve_addr  input  ADDRESS_WIDTH  register to mark busy
- reserve_en  input  1  reservation strobe
- ready  output  1  1 = clear finished, ports active
- busy_count  output  ADDRESS_WIDTH+1  number of busy registers

## Operation
- States: CLEAR, RUN. Reset forces CLEAR, clear_cnt = 0, all busy bits = 0, busy_count = 0, ready = 0.
- CLEAR: each edge with reset low writes 0 to register[clear_cnt] and increments clear_cnt. On the edge that clears RAM_DEPTH-1, go to RUN and set ready = 1.
- CLEAR: write_en and reserve_en are ignored. read_data1/2 = 0, busy1/2 = 0.
- RUN: on a posedge with write_en, register[write_addr] <= write_data. When ZERO_REG=1 and write_addr=0, the write is dropped.
- Read: read_dataN = 0 if ZERO_REG and read_addrN=0.
  - Otherwise it is write_data if write_en and write_addr == read_addrN (bypass).
  - Otherwise it is register[read_addrN].
- Scoreboard (RUN only):
  - reserve_en sets busy[reserve_addr].
  - write_en clears busy[write_addr].
  - Same address for both on one edge: set wins, so the bit stays 1.
  - Reserving an already-busy register leaves it busy.
  - Writing to a non-busy register is legal and leaves the bit at 0.
  - ZERO_REG=1: busy[0] stays 0.
- busyN = busy[read_addrN] AND NOT (write_en AND write_addr == read_addrN AND the same-edge reserve does not target it). This keeps busy consistent with the bypass.
- busy_count tracks the population of the busy vector after each edge. Its net change per edge is -1, 0 or +1, and it never exceeds RAM_DEPTH.

## Timing
- Read ports, bypass, busy1/2: combinational, zero latency.
- Write, reserve, release: take effect at the posedge where they are sampled and are visible in register state the following cycle.
- ready rises after RAM_DEPTH edges with reset low following the last reset-high edge (8 cycles at defaults).
- Reset asserted mid-CLEAR or mid-RUN: next edge returns to CLEAR with clear_cnt = 0, scoreboard flushed, register contents cleared again by the FSM.
- Reset dominates write_en and reserve_en on the same edge.
- clear_cnt wraps only via the state transition; it is never used in RUN.

## Test plan
- Reset high for 2 cycles, then low: ready = 0 for 8 cycles, rises on the 8th edge; all registers then read 0 and busy_count = 0.
- RUN: write 16'hBEEF to reg 5 with read_addr1 = 5 on the same cycle: read_data1 = 16'hBEEF combinationally; the next cycle without write_en still reads 16'hBEEF.
- ZERO_REG=1: write 16'h1234 to reg 0 and reserve reg 0: read_data = 0, busy = 0, busy_count unchanged.
- Reserve regs 3 and 4 on consecutive cycles: busy_count = 2, busy1 = 1 for addr 3. Write reg 3: busy1 drops in the same cycle, busy_count = 1 after the edge. Reserve and write reg 4 on one edge: busy[4] stays 1, busy_count stays 1.
- Write 16'h00FF to reg 2, reserve reg 6, then assert reset for 1 cycle mid-RUN: busy_count = 0 immediately after the edge, ready = 0, writes ignored during the 8 clear cycles, reg 2 reads 0 once ready = 1.
- Issue write_en and reserve_en during CLEAR: no register or busy change, and ready timing is unaffected.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port with write-to-read
// bypass, an optional hardwired zero register and a per-register busy scoreboard.
module regfile_scoreboard #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 3,
    parameter int RAM_DEPTH     = 1 << ADDRESS_WIDTH,
    parameter int ZERO_REG      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] read_addr1,
    input  logic [ADDRESS_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0]    read_data1,
    output logic [DATA_WIDTH-1:0]    read_data2,
    output logic                     busy1,
    output logic                     busy2,
    input  logic [ADDRESS_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_en,
    input  logic [ADDRESS_WIDTH-1:0] reserve_addr,
    input  logic                     reserve_en,
    output logic                     ready,
    output logic [ADDRESS_WIDTH:0]   busy_count
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] clear_cnt;
    logic [DATA_WIDTH-1:0]    regs [RAM_DEPTH];
    logic [RAM_DEPTH-1:0]     busy, busy_next;

    logic run;
    logic write_act;
    logic write_store;
    logic reserve_act;

    function automatic logic [ADDRESS_WIDTH:0] popcount(input logic [RAM_DEPTH-1:0] v);
        logic [ADDRESS_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < RAM_DEPTH; i++) begin
            cnt = cnt + {{ADDRESS_WIDTH{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDRESS_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign run         = (state == RUN);
    assign ready       = run;
    assign write_act   = run && write_en;
    assign write_store = write_act && !is_zero_reg(write_addr);
    assign reserve_act = run && reserve_en && !is_zero_reg(reserve_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clear_cnt <= '0;
        end else begin
            state     <= state_next;
            if (state == CLEAR) begin
                clear_cnt <= clear_cnt + ADDRESS_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clear_cnt == ADDRESS_WIDTH'(RAM_DEPTH - 1)) begin
            state_next = RUN;
        end
    end

    // Register array is cleared by the FSM rather than by reset, so a reset edge only blocks writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clear_cnt] <= '0;
            end else if (write_store) begin
                regs[write_addr] <= write_data;
            end
        end
    end

    // Release first, then reservation, so a same-edge reserve wins.
    always_comb begin
        busy_next = busy;
        if (write_act) begin
            busy_next[write_addr] = 1'b0;
        end
        if (reserve_act) begin
            busy_next[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= popcount(busy_next);
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDRESS_WIDTH-1:0] addr);
        if (!run || is_zero_reg(addr)) begin
            return '0;
        end else if (write_act && write_addr == addr) begin
            return write_data;
        end
        return regs[addr];
    endfunction

    // A same-cycle write releases the register unless a same-cycle reserve re-claims it.
    function automatic logic busy_port(input logic [ADDRESS_WIDTH-1:0] addr);
        logic released;
        released = write_act && write_addr == addr && !(reserve_act && reserve_addr == addr);
        return run && busy[addr] && !released;
    endfunction

    assign read_data1 = read_port(read_addr1);
    assign read_data2 = read_port(read_addr2);
    assign busy1      = busy_port(read_addr1);
    assign busy2      = busy_port(read_addr2);

endmodule
